game_tick_gen: RTL and testbench
================================

// Module: game_tick_gen
// PURPOSE
//  Multi-channel programmable rate generator for the game timing layer: gravity, pipe scroll, animation.
//  Each channel emits a one-cycle tick every P cycles. P is programmable at run time.
//  A new P takes effect glitch-free at the channel's next wrap.
//  Global pause freezes all channels. Per-channel enable gates a single channel.
// PARAMETERS
//  NUM_CH     2     number of tick channels (1..8)
//  CNT_W      11    counter/period width; legal P range 1..2**CNT_W-1
//  DEF_PERIOD 1024  reset period of ch0; ch k resets to max(DEF_PERIOD>>k,1) (ch1 = 2x ch0 rate)
// PORTS
//  clk          in   1                 system clock, all logic on posedge
//  reset        in   1                 synchronous, active-low reset
//  pause        in   1                 1 = freeze every channel counter, suppress ticks
//  ch_en        in   NUM_CH            per-channel enable
//  period_wr    in   1                 write strobe, one cycle
//  period_sel   in   $clog2(NUM_CH)+1  target channel of write
//  period_data  in   CNT_W             new period P (0 = halt channel)
//  period_busy  out  NUM_CH            1 = write pending on that channel, not yet applied
//  tick         out  NUM_CH            registered one-cycle tick pulse per channel
// BEHAVIOUR
//  Reset (reset==0 at posedge), all fields:
//   - cnt = 0, period = default, pending empty.
//   - tick = 0, period_busy = 0.
//  Counting, per channel, when pause==0, ch_en[k]==1 and period[k]!=0:
//   - cnt increments each cycle.
//   - When cnt==period-1: cnt<=0 (wrap), and tick[k]=1 on the next cycle.
//   - Tick period is exactly P cycles. First tick after reset/enable comes P cycles later.
//   - P==1 gives tick high every cycle.
//  Pause:
//   - cnt holds, no wrap, tick=0.
//   - Pending writes stay pending.
//   - On release, counting resumes from the held cnt, so phase is preserved.
//  ch_en[k]==0:
//   - cnt forced to 0, tick 0.
//   - A pending write on that channel is applied immediately (next cycle).
//  period[k]==0: channel halted as for ch_en==0. A pending write is applied immediately.
//  Write:
//   - period_wr with period_sel<NUM_CH stores period_data in the pending[sel] slot; busy[sel]=1 next cycle.
//   - Out-of-range period_sel is ignored.
//   - A second write while busy overwrites pending (last write wins).
//  Apply:
//   - On the wrap cycle, period<=pending, busy<=0, cnt<=0.
//   - If the new P is below the old cnt, no issue: apply only happens at wrap.
//  Write on the same cycle as a wrap of that channel:
//   - The wrap applies the old pending (if any).
//   - The new data becomes pending, busy=1.
//  All other arithmetic is unsigned CNT_W bits. cnt never exceeds period-1.
//  Reset mid-operation: everything returns to reset values next cycle; pending writes are discarded.
// CONFIGURATION
//  GAME_TICK_SYNC_EN defined:
//   - Adds input port sync (1 bit).
//   - sync==1 forces all cnt to 0 next cycle and suppresses tick that cycle. Pending is untouched.
//   - This re-aligns channel phases at game restart.
//   - sync has priority over pause. reset has priority over sync.
//  Not defined: port absent, no phase-realign path; behaviour otherwise identical.
// STRUCTURE
//  Package game_tick_pkg:
//   - MAX_CH = 8.
//   - Localparam function def_period(k) returning max(DEF_PERIOD>>k,1).
//   - typedef struct ch_cfg_t {period, pending, busy}.
//  Sub-module game_tick_chan: one counter/period/pending/tick slice.
//  The top generates NUM_CH copies and decodes period_wr/period_sel.
// TESTING
//  1. Reset; ch_en=2'b11; run 4096 cycles -> ch0 ticks at 1024,2048,..; ch1 at 512,1024,..; each pulse 1 cycle.
//  2. ch0 mid-count (cnt=300): write P=10 -> busy[0]=1 until the wrap at cnt 1023; then ticks every 10 cycles, busy=0.
//  3. pause=1 for 50 cycles at ch1 cnt=200 -> no ticks, cnt held; next tick lands exactly 50 cycles late.
//  4. Write P=5 on ch1 on the cycle its cnt=511 -> wrap keeps P=512 once, busy=1, then P=5 applied at next wrap.
//  5. Write P=0 to ch0 then P=3 -> ch0 halts; P=3 applied next cycle (halted); first tick 3 cycles after apply.
//  6. (GAME_TICK_SYNC_EN) ch0 cnt=700, ch1 cnt=100, pulse sync -> both cnt=0; ch0 ticks 1024, ch1 512 cycles later.

Source files
------------

// File: rtl/game_tick_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_tick_pkg                                                 |
// | Purpose  : Shared constants, per-channel config record and the reset     |
// |            period helper for the game tick generator.                    |
// | Macros   : none (GAME_TICK_SYNC_EN is consumed by game_tick_gen)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package game_tick_pkg;

  // Upper bound on channel count.
  localparam int MAX_CH    = 8;

  // Storage width of the config record. Channels keep their state at this
  // width; every value ever loaded is below 2**CNT_W, so the arithmetic
  // behaves exactly as CNT_W-bit arithmetic. CNT_W must not exceed this.
  localparam int MAX_CNT_W = 16;

  typedef struct packed {
    logic [MAX_CNT_W-1:0] period;   // active period, 0 = halted
    logic [MAX_CNT_W-1:0] pending;  // next period, applied at wrap/halt
    logic                 busy;     // pending slot holds an unapplied write
  } ch_cfg_t;

  // Reset period of channel k: max(def >> k, 1).
  function automatic logic [MAX_CNT_W-1:0] def_period(input int unsigned def,
                                                      input int unsigned k);
    int unsigned v;
    v = def >> k;
    if (v == 0) begin
      v = 1;
    end
    return MAX_CNT_W'(v);
  endfunction

endpackage : game_tick_pkg
`default_nettype wire

// File: rtl/game_tick_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_tick_gen_if                                              |
// | Purpose  : Control/status bundle of the game tick generator.             |
// | Signals  : pause        master->slave  freeze all channels               |
// |            ch_en        master->slave  per-channel enable                |
// |            period_wr    master->slave  one-cycle write strobe            |
// |            period_sel   master->slave  target channel of the write       |
// |            period_data  master->slave  new period (0 = halt)             |
// |            period_busy  slave->master  write pending per channel         |
// |            tick         slave->master  one-cycle tick per channel        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface game_tick_gen_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 11
);

  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic              pause;
  logic [NUM_CH-1:0] ch_en;
  logic              period_wr;
  logic [SEL_W-1:0]  period_sel;
  logic [CNT_W-1:0]  period_data;
  logic [NUM_CH-1:0] period_busy;
  logic [NUM_CH-1:0] tick;

  modport master (
    output pause, ch_en, period_wr, period_sel, period_data,
    input  period_busy, tick
  );

  modport slave (
    input  pause, ch_en, period_wr, period_sel, period_data,
    output period_busy, tick
  );

endinterface : game_tick_gen_if
`default_nettype wire

// File: rtl/game_tick_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_tick_chan                                                |
// | Purpose  : One tick channel: free-running counter, active period,        |
// |            pending-period slot and registered tick pulse.                |
// | Ports    : clk        system clock                                       |
// |            reset      synchronous active-low reset                       |
// |            i_pause    freeze counter, suppress tick                      |
// |            i_en       channel enable                                     |
// |            i_sync     force counter to 0 (phase realign)                 |
// |            i_wr       write strobe already decoded for this channel      |
// |            i_wr_data  new period                                         |
// |            o_tick     one-cycle tick, cycle after the wrap               |
// |            o_busy     pending write not yet applied                      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module game_tick_chan
  import game_tick_pkg::*;
#(
  parameter int                   CNT_W = 11,
  parameter logic [MAX_CNT_W-1:0] DEF_P = MAX_CNT_W'(1024)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_pause,
  input  wire logic             i_en,
  input  wire logic             i_sync,
  input  wire logic             i_wr,
  input  wire logic [CNT_W-1:0] i_wr_data,
  output logic                  o_tick,
  output logic                  o_busy
);

  ch_cfg_t              r_cfg;
  logic [MAX_CNT_W-1:0] r_cnt;
  logic                 r_tick;

  logic                 w_active;
  logic                 w_frozen;
  logic [MAX_CNT_W-1:0] w_period_m1;
  logic                 w_wrap;
  logic                 w_apply;

  assign w_active    = i_en && (r_cfg.period != '0);
  // sync and pause both stop the channel from advancing; sync additionally
  // clears the counter below.
  assign w_frozen    = i_sync || i_pause;
  assign w_period_m1 = r_cfg.period - MAX_CNT_W'(1);
  assign w_wrap      = !w_frozen && w_active && (r_cnt == w_period_m1);

  // A pending period is taken over at a wrap, or straight away while the
  // channel is halted (disabled or period 0). Frozen channels keep it pending.
  assign w_apply     = r_cfg.busy && !w_frozen && (w_wrap || !w_active);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cfg.period  <= DEF_P;
      r_cfg.pending <= '0;
      r_cfg.busy    <= 1'b0;
      r_cnt         <= '0;
      r_tick        <= 1'b0;
    end else begin
      r_tick <= w_wrap;

      if (i_sync || !w_active || w_wrap) begin
        r_cnt <= '0;
      end else if (!i_pause) begin
        r_cnt <= r_cnt + MAX_CNT_W'(1);
      end

      // The apply reads the pending slot before a same-cycle write replaces
      // it, so a write landing on a wrap stays pending for the next one.
      if (w_apply) begin
        r_cfg.period <= r_cfg.pending;
      end

      if (i_wr) begin
        r_cfg.pending <= MAX_CNT_W'(i_wr_data);
        r_cfg.busy    <= 1'b1;
      end else if (w_apply) begin
        r_cfg.busy    <= 1'b0;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_busy = r_cfg.busy;

endmodule : game_tick_chan
`default_nettype wire

// File: rtl/game_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_tick_gen                                                 |
// | Purpose  : Multi-channel programmable rate generator (gravity, pipe      |
// |            scroll, animation). Each channel ticks once every P cycles;   |
// |            a new P is taken over glitch-free at the channel's next wrap. |
// | Ports    : clk    system clock                                           |
// |            reset  synchronous active-low reset                           |
// |            sync   (GAME_TICK_SYNC_EN only) realign all channel phases    |
// |            bus    game_tick_gen_if.slave control/status bundle           |
// | Macros   : GAME_TICK_SYNC_EN - adds the sync input                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module game_tick_gen
  import game_tick_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = 11,
  parameter int DEF_PERIOD = 1024
) (
  input  wire logic      clk,
  input  wire logic      reset,
`ifdef GAME_TICK_SYNC_EN
  input  wire logic      sync,
`endif
  game_tick_gen_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_CH) + 1;

  logic              w_sync;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_busy;

`ifdef GAME_TICK_SYNC_EN
  assign w_sync = sync;
`else
  assign w_sync = 1'b0;
`endif

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      // Out-of-range selects match no channel and are dropped here.
      assign w_wr[k] = bus.period_wr && (bus.period_sel == SEL_W'(k));

      game_tick_chan #(
        .CNT_W (CNT_W),
        .DEF_P (def_period(DEF_PERIOD, k))
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .i_pause   (bus.pause),
        .i_en      (bus.ch_en[k]),
        .i_sync    (w_sync),
        .i_wr      (w_wr[k]),
        .i_wr_data (bus.period_data),
        .o_tick    (w_tick[k]),
        .o_busy    (w_busy[k])
      );
    end
  endgenerate

  assign bus.tick        = w_tick;
  assign bus.period_busy = w_busy;

endmodule : game_tick_gen
`default_nettype wire

// File: tb/tb_game_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_game_tick_gen                                              |
// | Purpose  : Directed self-checking bench for game_tick_gen (2 channels,   |
// |            CNT_W 11, DEF_PERIOD 1024).                                   |
// | Macros   : GAME_TICK_SYNC_EN - enables the sync realign scenario         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_game_tick_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
`ifdef GAME_TICK_SYNC_EN
  logic sync  = 1'b0;
`endif

  game_tick_gen_if #(.NUM_CH(2), .CNT_W(11)) bus ();

  game_tick_gen #(
    .NUM_CH     (2),
    .CNT_W      (11),
    .DEF_PERIOD (1024)
  ) dut (
    .clk   (clk),
    .reset (reset),
`ifdef GAME_TICK_SYNC_EN
    .sync  (sync),
`endif
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ec    = 0;   // posedges since reset release

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    bus.pause       = 1'b0;
    bus.ch_en       = 2'b00;
    bus.period_wr   = 1'b0;
    bus.period_sel  = '0;
    bus.period_data = '0;
    step(2);
    reset = 1'b1;
    ec    = 0;
  endtask

  // Present one write; it is sampled on the next edge.
  task automatic wr(input int sel, input int data);
    bus.period_wr   = 1'b1;
    bus.period_sel  = 2'(sel);
    bus.period_data = 11'(data);
    step(1);
    bus.period_wr   = 1'b0;
  endtask

  // Edge count of the next tick on channel ch, -1 if none within limit.
  task automatic wait_tick(input int ch, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (bus.tick[ch] === 1'b1) begin
        at = ec;
        break;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, n0, n1, at, cnt;

    // Reset state
    do_reset();
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_busy", int'(bus.period_busy), 0);

    // 1: default rates, ch0 every 1024, ch1 every 512
    bus.ch_en = 2'b11;
    e0 = 0; e1 = 0; n0 = 0; n1 = 0;
    for (int i = 1; i <= 4096; i++) begin
      step(1);
      if (bus.tick[0] !== ((ec % 1024) == 0)) e0++;
      if (bus.tick[1] !== ((ec % 512) == 0))  e1++;
      n0 += int'(bus.tick[0]);
      n1 += int'(bus.tick[1]);
    end
    chk("t1_ch0_err", e0, 0);
    chk("t1_ch1_err", e1, 0);
    chk("t1_ch0_n",   n0, 4);
    chk("t1_ch1_n",   n1, 8);

    // 2: mid-count rewrite of ch0, last write wins, applied at wrap
    step(300);                    // ch0 cnt = 300
    wr(0, 20);
    chk("t2_busy_set", int'(bus.period_busy[0]), 1);
    wr(0, 10);                    // ec 4398
    step(5119 - ec);
    chk("t2_busy_hold", int'(bus.period_busy[0]), 1);
    chk("t2_no_tick",   int'(bus.tick[0]), 0);
    step(1);                      // ec 5120: wrap with old P
    chk("t2_wrap_tick", int'(bus.tick[0]), 1);
    chk("t2_busy_clr",  int'(bus.period_busy[0]), 0);
    step(9);
    chk("t2_p10_early", int'(bus.tick[0]), 0);
    step(1);
    chk("t2_p10_tick",  int'(bus.tick[0]), 1);

    // 3: pause 50 cycles at cnt 200, phase preserved
    do_reset();
    bus.ch_en = 2'b11;
    step(200);
    bus.pause = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      cnt += int'(bus.tick[0]) + int'(bus.tick[1]);
    end
    bus.pause = 1'b0;
    chk("t3_pause_ticks", cnt, 0);
    wait_tick(1, 600, at);
    chk("t3_ch1_first", at, 562);
    wait_tick(0, 600, at);
    chk("t3_ch0_first", at, 1074);

    // 4: write on ch1's wrap cycle keeps old P once
    do_reset();
    bus.ch_en = 2'b11;
    step(511);
    wr(1, 5);                     // sampled on wrap edge 512
    chk("t4_wrap_tick", int'(bus.tick[1]), 1);
    chk("t4_busy_set",  int'(bus.period_busy[1]), 1);
    step(511);
    chk("t4_old_p_wait", int'(bus.tick[1]), 0);
    chk("t4_busy_hold",  int'(bus.period_busy[1]), 1);
    step(1);
    chk("t4_old_p_tick", int'(bus.tick[1]), 1);
    chk("t4_busy_clr",   int'(bus.period_busy[1]), 0);
    step(4);
    chk("t4_p5_early", int'(bus.tick[1]), 0);
    step(1);
    chk("t4_p5_tick",  int'(bus.tick[1]), 1);

    // 5: halt via P=0, then P=3 applied while halted; bad select ignored
    do_reset();
    bus.ch_en = 2'b11;
    wr(0, 0);
    chk("t5_busy0", int'(bus.period_busy[0]), 1);
    wr(2, 7);
    chk("t5_bad_sel", int'(bus.period_busy), 1);
    step(1021);                   // ec 1023
    chk("t5_busy_hold", int'(bus.period_busy[0]), 1);
    step(1);
    chk("t5_last_tick", int'(bus.tick[0]), 1);
    chk("t5_busy_clr",  int'(bus.period_busy[0]), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      cnt += int'(bus.tick[0]);
    end
    chk("t5_halted", cnt, 0);
    wr(0, 3);                     // ec 1030
    chk("t5_busy_p3", int'(bus.period_busy[0]), 1);
    step(1);                      // applied while halted
    chk("t5_applied", int'(bus.period_busy[0]), 0);
    step(2);
    chk("t5_p3_early", int'(bus.tick[0]), 0);
    step(1);
    chk("t5_p3_tick",  int'(bus.tick[0]), 1);
    step(3);
    chk("t5_p3_tick2", int'(bus.tick[0]), 1);

`ifdef GAME_TICK_SYNC_EN
    // 6: sync realigns both channels
    do_reset();
    bus.ch_en = 2'b01;
    step(600);
    bus.ch_en = 2'b11;
    step(100);                    // ch0 cnt 700, ch1 cnt 100
    sync = 1'b1;
    step(1);
    sync = 1'b0;
    chk("t6_sync_tick", int'(bus.tick), 0);
    wait_tick(1, 600, at);
    chk("t6_ch1_first", at, 1213);
    wait_tick(0, 600, at);
    chk("t6_ch0_first", at, 1725);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_game_tick_gen
`default_nettype wire
